// File: rtl/sm_prefetch.sv
// Instruction prefetch queue: one-outstanding fetch engine feeding a DEPTH-entry PC-tagged FIFO.
// Optional SM_PREFETCH_BYPASS_EN forwards an acked word straight to the core when the queue is empty.
module sm_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    input  logic        instrReady,
    output logic        instrValid,
    output logic [31:0] instrData,
    output logic [31:0] instrPc,
    output logic        memReq,
    output logic [31:0] memAddr,
    input  logic        memAck,
    input  logic [31:0] memData
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [PTR_W-1:0]   rdPtr;
    logic [PTR_W-1:0]   wrPtr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   countAfter;
    logic [31:0]        fetchPc;
    logic [31:0]        fetchPcNext;
    logic               memReqNext;
    logic [31:0]        memAddrNext;
    logic [31:0]        qData [DEPTH];
    logic [31:0]        qPc   [DEPTH];
    logic               headValid;
    logic               bypassHit;
    logic               bypassTake;
    logic               push;
    logic               pop;
    logic               space;

    // Queue control; space means a slot is left for a further outstanding request
    always_comb begin
        headValid  = (count != '0);
        bypassHit  = 1'b0;
`ifdef SM_PREFETCH_BYPASS_EN
        bypassHit  = !headValid && memAck && (state == REQ) && !redirect;
`endif
        bypassTake = bypassHit && instrReady;
        pop        = headValid && instrReady && !redirect;
        push       = (state == REQ) && memAck && !redirect && !bypassTake;
        countAfter = count + CNT_W'(push) - CNT_W'(pop);
        space      = (countAfter < CNT_W'(DEPTH));
    end

    // Core-facing outputs
    always_comb begin
`ifdef SM_PREFETCH_BYPASS_EN
        instrValid = headValid || bypassHit;
        instrData  = bypassHit ? memData : qData[rdPtr];
        instrPc    = bypassHit ? memAddr : qPc[rdPtr];
`else
        instrValid = headValid;
        instrData  = qData[rdPtr];
        instrPc    = qPc[rdPtr];
`endif
    end

    // Fetch FSM next state and next request registers
    always_comb begin
        stateNext   = state;
        memReqNext  = memReq;
        memAddrNext = memAddr;
        fetchPcNext = fetchPc;
        case (state)
            IDLE: begin
                if (space) begin
                    stateNext   = REQ;
                    memReqNext  = 1'b1;
                    memAddrNext = fetchPc;
                end
            end
            REQ: begin
                if (memAck) begin
                    fetchPcNext = fetchPc + 32'd1;
                    if (space) begin
                        memAddrNext = fetchPc + 32'd1;
                    end else begin
                        stateNext  = IDLE;
                        memReqNext = 1'b0;
                    end
                end
            end
            DROP: begin
                if (memAck) begin
                    stateNext   = REQ;
                    memReqNext  = 1'b1;
                    memAddrNext = fetchPc;
                end
            end
            default: begin
                stateNext  = IDLE;
                memReqNext = 1'b0;
            end
        endcase
        // Redirect wins, but an unacked request must still complete before refetching
        if (redirect) begin
            fetchPcNext = redirectPc;
            if ((state == IDLE) || memAck) begin
                stateNext   = REQ;
                memReqNext  = 1'b1;
                memAddrNext = redirectPc;
            end else begin
                stateNext = DROP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc <= RESET_PC;
            memReq  <= 1'b0;
            memAddr <= RESET_PC;
        end else begin
            fetchPc <= fetchPcNext;
            memReq  <= memReqNext;
            memAddr <= memAddrNext;
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                qData[i] <= '0;
                qPc[i]   <= '0;
            end
        end else if (redirect) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                qData[wrPtr] <= memData;
                qPc[wrPtr]   <= memAddr;
                wrPtr        <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= countAfter;
        end
    end

endmodule

// File: tb/tb_sm_prefetch.sv
// Self-checking bench for sm_prefetch: directed scenarios plus random traffic against a
// transaction-level model (expected fetch stream, delivered-word queue, stale-request flag).
module tb_sm_prefetch;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        instrReady;
    logic        instrValid;
    logic [31:0] instrData;
    logic [31:0] instrPc;
    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memData;

    always #5 clk = ~clk;

    sm_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .redirect   (redirect),
        .redirectPc (redirectPc),
        .instrReady (instrReady),
        .instrValid (instrValid),
        .instrData  (instrData),
        .instrPc    (instrPc),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memAck     (memAck),
        .memData    (memData)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] expAddr;
    bit          stale;
    bit          expReq;
    bit          holdChk;
    logic [31:0] holdAddr;
    int          tests  = 0;
    int          failed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        expAddr = 32'h0;
        stale   = 1'b0;
        expReq  = 1'b0;
        holdChk = 1'b0;
    endtask

    task automatic checkOut();
        chk("instrValid", 32'(instrValid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("instrPc", instrPc, q[0].pc);
            chk("instrData", instrData, q[0].data);
        end
        chk("memReq", 32'(memReq), 32'(expReq));
        if (memReq && !stale) chk("memAddr", memAddr, expAddr);
        if (holdChk) chk("memAddrHold", memAddr, holdAddr);
    endtask

    // One clock: drive inputs at negedge, advance the model, check after the next posedge
    task automatic step(input bit ack, input bit rdy, input bit red,
                        input logic [31:0] rpc, input logic [31:0] dat);
        memAck     = ack;
        instrReady = rdy;
        redirect   = red;
        redirectPc = rpc;
        memData    = dat;
        holdChk    = memReq && !ack;
        holdAddr   = memAddr;
        if (!red && q.size() > 0 && rdy) void'(q.pop_front());
        if (memReq && ack) begin
            if (stale) begin
                stale = 1'b0;
            end else if (!red) begin
                q.push_back('{pc: memAddr, data: dat});
                expAddr = memAddr + 32'd1;
            end
        end
        if (red) begin
            q.delete();
            expAddr = rpc;
            if (memReq && !ack) stale = 1'b1;
        end
        expReq = (memReq && !ack) || (q.size() < int'(DEPTH));
        @(posedge clk);
        @(negedge clk);
        checkOut();
    endtask

    task automatic go(input bit ack, input bit rdy);
        step(ack, rdy, 1'b0, 32'h0, memAddr ^ 32'hA5A5_0000);
    endtask

    initial begin
        rst        = 1'b1;
        redirect   = 1'b0;
        redirectPc = 32'h0;
        instrReady = 1'b0;
        memAck     = 1'b0;
        memData    = 32'h0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_memReq", 32'(memReq), 32'h0);
        chk("rst_memAddr", memAddr, 32'h0);
        chk("rst_instrValid", 32'(instrValid), 32'h0);
        chk("rst_instrData", instrData, 32'h0);
        chk("rst_instrPc", instrPc, 32'h0);
        rst = 1'b0;

        // Streaming with zero-wait memory: first valid two cycles after reset release
        go(1'b1, 1'b1);
        chk("lat_cycle1_valid", 32'(instrValid), 32'h0);
        go(1'b1, 1'b1);
        chk("lat_cycle2_valid", 32'(instrValid), 32'h1);
        chk("lat_first_pc", instrPc, 32'h0);
        chk("lat_first_data", instrData, 32'hA5A5_0000);
        for (int i = 0; i < 8; i++) go(1'b1, 1'b1);

        // Core stalls: queue fills, requests stop, then drain and resume
        for (int i = 0; i < 8; i++) go(1'b1, 1'b0);
        chk("full_memReq", 32'(memReq), 32'h0);
        for (int i = 0; i < 8; i++) go(1'b1, 1'b1);

        // Slow memory: address held, exactly one push on ack
        for (int i = 0; i < 5; i++) go(1'b0, 1'b1);
        go(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) go(1'b0, 1'b1);

        // Redirect against an unacked request: stale ack discarded, refetch at 0x40
        step(1'b0, 1'b0, 1'b1, 32'h40, 32'h0);
        chk("drop_valid", 32'(instrValid), 32'h0);
        go(1'b0, 1'b0);
        go(1'b1, 1'b0);
        chk("drop_refetch_addr", memAddr, 32'h40);
        go(1'b1, 1'b1);
        chk("drop_first_pc", instrPc, 32'h40);
        for (int i = 0; i < 4; i++) go(1'b1, 1'b1);

        // Redirect coinciding with ack and ready
        go(1'b1, 1'b0);
        go(1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF);
        chk("redir_ack_valid", 32'(instrValid), 32'h0);
        chk("redir_ack_addr", memAddr, 32'h100);
        for (int i = 0; i < 4; i++) go(1'b1, 1'b1);

        // Reset asserted with three queued words and a pending request
        step(1'b1, 1'b0, 1'b1, 32'h200, 32'h0);
        for (int i = 0; i < 3; i++) go(1'b1, 1'b0);
        go(1'b0, 1'b0);
        chk("pre_rst_valid", 32'(instrValid), 32'h1);
        chk("pre_rst_memReq", 32'(memReq), 32'h1);
        memAck = 1'b1;
        rst    = 1'b1;
        #1;
        chk("async_rst_valid", 32'(instrValid), 32'h0);
        chk("async_rst_memReq", 32'(memReq), 32'h0);
        chk("async_rst_memAddr", memAddr, 32'h0);
        modelReset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) go(1'b1, 1'b1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 4, $urandom, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
